// File: rtl/branch_sequencer_if.sv
// Decode-to-sequencer bundle: instruction flags and target in, fetch address and
// sequencer status out.
interface branch_sequencer_if #(
  parameter int AW    = 8,
  parameter int DEPTH = 4
);
  logic                       stall;
  logic                       instr_valid;
  logic                       is_branch;
  logic                       is_ret;
  logic [1:0]                 cond;
  logic [AW-1:0]              target;
  logic [AW-1:0]              pc;
  logic                       fetch_en;
  logic                       flush;
  logic                       fault;
  logic [$clog2(DEPTH+1)-1:0] sp;

  modport master (
    output stall, instr_valid, is_branch, is_ret, cond, target,
    input  pc, fetch_en, flush, fault, sp
  );

  modport slave (
    input  stall, instr_valid, is_branch, is_ret, cond, target,
    output pc, fetch_en, flush, fault, sp
  );
endinterface

// File: rtl/branch_sequencer.sv
// PC sequencer: owns the fetch address, a return-address stack and the one-cycle
// redirect bubble.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_RUN    | fetching; PC advances or redirects on accepted instructions
//   ST_BUBBLE | one cycle after a redirect; the stale fetch is flushed
//   ST_HALT   | stack overflow/underflow seen; frozen until rst
module branch_sequencer #(
  parameter int AW       = 8,
  parameter int DEPTH    = 4,
  parameter int RESET_PC = 0
) (
  input logic              clk,
  input logic              rst,
  branch_sequencer_if.slave bus
);
  localparam int SPW  = $clog2(DEPTH + 1);
  localparam int IDXW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_BUBBLE = 2'd1,
    ST_HALT   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic [SPW-1:0]  sp_q, sp_d;
  logic [AW-1:0]   stack_q [DEPTH];
  logic            push_en;
  logic [AW-1:0]   pc_inc;
  logic [IDXW-1:0] pop_idx;
  logic [IDXW-1:0] push_idx;
  logic            sp_empty;
  logic            sp_full;

  assign pc_inc   = pc_q + AW'(1);
  assign pop_idx  = IDXW'(sp_q - SPW'(1));
  assign push_idx = IDXW'(sp_q);
  assign sp_empty = (sp_q == '0);
  assign sp_full  = (sp_q == SPW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      pc_q    <= AW'(RESET_PC);
      sp_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
    end
  end

  // Stack contents survive reset; only entries below sp are ever read.
  always_ff @(posedge clk) begin
    if (push_en && !rst) begin
      stack_q[push_idx] <= pc_inc;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    push_en = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (!bus.stall) begin
          if (!bus.instr_valid) begin
            pc_d = pc_inc;
          end else if (bus.is_ret) begin
            if (sp_empty) begin
              state_d = ST_HALT;
            end else begin
              pc_d    = stack_q[pop_idx];
              sp_d    = sp_q - SPW'(1);
              state_d = ST_BUBBLE;
            end
          end else if (bus.is_branch && bus.cond == 2'b01) begin
            pc_d    = bus.target;
            state_d = ST_BUBBLE;
          end else if (bus.is_branch && bus.cond == 2'b11) begin
            if (sp_full) begin
              state_d = ST_HALT;
            end else begin
              push_en = 1'b1;
              sp_d    = sp_q + SPW'(1);
              pc_d    = bus.target;
              state_d = ST_BUBBLE;
            end
          end else begin
            // Not taken, including the reserved code 2'b10.
            pc_d = pc_inc;
          end
        end
      end
      ST_BUBBLE: state_d = ST_RUN;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_HALT;
    endcase
  end

  always_comb begin
    bus.fetch_en = (state_q == ST_RUN);
    bus.flush    = (state_q == ST_BUBBLE);
    bus.fault    = (state_q == ST_HALT);
  end

  assign bus.pc = pc_q;
  assign bus.sp = sp_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// Two sequencers (reset PC 00 and FE) driven in lockstep and checked every cycle
// against a queue-based model, plus literal expectations for directed scenarios.
module tb_branch_sequencer;
  localparam int AW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          s_stall = 1'b0;
  logic          s_iv    = 1'b0;
  logic          s_br    = 1'b0;
  logic          s_ret   = 1'b0;
  logic [1:0]    s_cond  = 2'b00;
  logic [AW-1:0] s_tgt   = '0;

  branch_sequencer_if #(.AW(AW), .DEPTH(DEPTH)) bus0 ();
  branch_sequencer_if #(.AW(AW), .DEPTH(DEPTH)) bus1 ();

  assign bus0.stall = s_stall;  assign bus1.stall = s_stall;
  assign bus0.instr_valid = s_iv; assign bus1.instr_valid = s_iv;
  assign bus0.is_branch = s_br;  assign bus1.is_branch = s_br;
  assign bus0.is_ret = s_ret;    assign bus1.is_ret = s_ret;
  assign bus0.cond = s_cond;     assign bus1.cond = s_cond;
  assign bus0.target = s_tgt;    assign bus1.target = s_tgt;

  branch_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );
  branch_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_PC(8'hFE)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1.slave)
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: return stack as a queue, bubble/halt as flags.
  logic [AW-1:0] m_pc   [2];
  bit            m_bub  [2];
  bit            m_halt [2];
  logic [AW-1:0] m_stk  [2][$];
  bit            chk_on = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_pc[k]   = (k == 0) ? 8'h00 : 8'hFE;
        m_bub[k]  = 1'b0;
        m_halt[k] = 1'b0;
        m_stk[k].delete();
      end else if (m_halt[k]) begin
        // frozen
      end else if (m_bub[k]) begin
        m_bub[k] = 1'b0;
      end else if (s_stall) begin
        // hold
      end else if (!s_iv) begin
        m_pc[k] = m_pc[k] + 8'd1;
      end else if (s_ret) begin
        if (m_stk[k].size() == 0) m_halt[k] = 1'b1;
        else begin
          m_pc[k]  = m_stk[k].pop_back();
          m_bub[k] = 1'b1;
        end
      end else if (s_br && s_cond == 2'b01) begin
        m_pc[k]  = s_tgt;
        m_bub[k] = 1'b1;
      end else if (s_br && s_cond == 2'b11) begin
        if (m_stk[k].size() == DEPTH) m_halt[k] = 1'b1;
        else begin
          m_stk[k].push_back(m_pc[k] + 8'd1);
          m_pc[k]  = s_tgt;
          m_bub[k] = 1'b1;
        end
      end else begin
        m_pc[k] = m_pc[k] + 8'd1;
      end
    end
    if (rst) chk_on = 1'b1;
    #1;
    if (chk_on) begin
      check("model0", {18'd0, bus0.pc, bus0.sp, bus0.fetch_en, bus0.flush, bus0.fault},
            {18'd0, m_pc[0], 3'(m_stk[0].size()), !m_bub[0] && !m_halt[0], m_bub[0], m_halt[0]});
      check("model1", {18'd0, bus1.pc, bus1.sp, bus1.fetch_en, bus1.flush, bus1.fault},
            {18'd0, m_pc[1], 3'(m_stk[1].size()), !m_bub[1] && !m_halt[1], m_bub[1], m_halt[1]});
    end
  end

  task automatic step(input logic r, input logic st, input logic iv, input logic br,
                      input logic ret, input logic [1:0] c, input logic [7:0] t);
    @(negedge clk);
    rst = r; s_stall = st; s_iv = iv; s_br = br; s_ret = ret; s_cond = c; s_tgt = t;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 2'b00, 8'h00);
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0, 2'b00, 8'h00);
  endtask

  task automatic call(input logic [7:0] t);
    step(0, 0, 1, 1, 0, 2'b11, t);
  endtask

  task automatic ret_i();
    step(0, 0, 1, 0, 1, 2'b00, 8'h00);
  endtask

  initial begin
    // Reset then sequential run
    do_reset(); do_reset();
    check("rst_pc0", bus0.pc, 8'h00);
    check("rst_pc1", bus1.pc, 8'hFE);
    check("rst_out", {bus0.fetch_en, bus0.flush, bus0.fault, bus0.sp}, {3'b100, 3'd0});
    for (int i = 1; i <= 5; i++) begin
      idle();
      check("seq_pc", bus0.pc, 32'(i));
    end
    check("seq_wrap1", bus1.pc, 8'h03);

    // Taken jump with bubble, and not-taken codes
    do_reset(); idle(); idle(); idle();
    step(0, 0, 1, 1, 0, 2'b01, 8'h40);
    check("jmp_pc", bus0.pc, 8'h40);
    check("jmp_bub", {bus0.flush, bus0.fetch_en}, 2'b10);
    idle();
    check("bub_hold", {bus0.pc, bus0.flush, bus0.fetch_en}, {8'h40, 2'b01});
    idle();
    check("jmp_next", bus0.pc, 8'h41);
    do_reset(); idle(); idle(); idle();
    step(0, 0, 1, 1, 0, 2'b00, 8'h40);
    check("nt_pc", {bus0.pc, bus0.flush}, {8'h04, 1'b0});
    step(0, 0, 1, 1, 0, 2'b10, 8'h40);
    check("rsv_pc", {bus0.pc, bus0.flush}, {8'h05, 1'b0});

    // Call and return
    do_reset();
    for (int i = 0; i < 16; i++) idle();
    check("at_10", bus0.pc, 8'h10);
    call(8'h80);
    check("call", {bus0.pc, bus0.sp, bus0.flush}, {8'h80, 3'd1, 1'b1});
    idle(); idle(); idle();
    check("call_run", bus0.pc, 8'h82);
    ret_i();
    check("ret", {bus0.pc, bus0.sp, bus0.flush}, {8'h11, 3'd0, 1'b1});
    idle();
    check("ret_bub", {bus0.pc, bus0.fetch_en}, {8'h11, 1'b1});

    // Overflow
    do_reset();
    call(8'h20); idle(); call(8'h30); idle(); call(8'h40); idle(); call(8'h50); idle();
    check("ovf_sp4", {bus0.sp, bus0.pc}, {3'd4, 8'h50});
    call(8'h60);
    check("ovf", {bus0.fault, bus0.fetch_en, bus0.pc}, {2'b10, 8'h50});
    for (int i = 0; i < 10; i++) begin
      step(0, i[0], 1, 1, i[1], 2'b01, 8'h77);
      check("ovf_hold", {bus0.fault, bus0.pc}, {1'b1, 8'h50});
    end
    do_reset();
    check("ovf_clr", {bus0.fault, bus0.pc, bus0.sp}, {1'b0, 8'h00, 3'd0});

    // LIFO order across nested returns
    call(8'h20); idle(); call(8'h30); idle();
    ret_i(); check("lifo1", bus0.pc, 8'h21); idle();
    ret_i(); check("lifo2", bus0.pc, 8'h01); idle();

    // Underflow
    do_reset();
    ret_i();
    check("udf", {bus0.fault, bus0.pc, bus1.fault, bus1.pc}, {1'b1, 8'h00, 1'b1, 8'hFE});

    // Stall and wrap
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 1, 0, 2'b01, 8'h99);
      check("stall", {bus1.pc, bus1.sp, bus1.fetch_en}, {8'hFE, 3'd0, 1'b1});
    end
    idle(); check("wrap_ff", bus1.pc, 8'hFF);
    idle(); check("wrap_00", bus1.pc, 8'h00);
    do_reset(); idle();
    call(8'h70); idle();
    ret_i();
    check("push_wrap", {bus1.pc, bus1.sp}, {8'h00, 3'd0});

    // Priority and ignore during bubble
    do_reset(); idle();
    call(8'h30); idle();
    step(0, 0, 1, 1, 1, 2'b01, 8'h55);
    check("prio", {bus0.pc, bus0.sp}, {8'h02, 3'd0});
    step(0, 0, 1, 1, 0, 2'b11, 8'h99);
    check("bub_ign", {bus0.pc, bus0.sp, bus0.fetch_en}, {8'h02, 3'd0, 1'b1});

    // Randomized traffic, checked by the model each cycle
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 5) == 0), 2'($urandom_range(0, 3)),
           8'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule

// File: doc/branch_sequencer.md
# branch_sequencer

Program-counter sequencer for the team's microprocessor. It consumes the 2-bit jump-condition code from the jump decoder, together with the branch target and return indication from instruction decode. It owns the PC, a hardware return-address stack and the fetch-redirect bubble. It sits between decode and the instruction-memory address port and is the only writer of the PC.

## Interface
- AW, 8: PC / target address width.
- DEPTH, 4: return-stack entries (power of two, ≥2).
- RESET_PC, 0: PC value loaded on reset.

- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  synchronous reset, active-high.
- STALL  in  1  pipeline hold; freezes PC, stack and state in RUN.
- INSTR_VALID  in  1  decode presents a valid instruction this cycle.
- IS_BRANCH  in  1  instruction is a jump/call; COND is meaningful.
- IS_RET  in  1  instruction is a return.
- COND  in  2  jump decoder code: 00 not taken, 01 jump, 11 call, 10 reserved.
- TARGET  in  AW  branch/call destination.
- PC  out  AW  current fetch address (registered).
- FETCH_EN  out  1  instruction memory read enable.
- FLUSH  out  1  discard the instruction fetched in the previous cycle.
- FAULT  out  1  stack overflow/underflow; sticky until reset.
- SP  out  clog2(DEPTH+1)  number of valid stack entries.

## Operation
- States: RUN, BUBBLE, HALT. Outputs decode from registered state: FETCH_EN=(RUN), FLUSH=(BUBBLE), FAULT=(HALT).
- RUN, STALL=1: PC, SP, stack and state hold. All other inputs are ignored.
- RUN, STALL=0, INSTR_VALID=0: PC←PC+1.
- RUN, STALL=0, INSTR_VALID=1, priority order:
  - IS_RET=1 (IS_BRANCH ignored): if SP=0, go to HALT and hold PC. Otherwise PC←stack[SP-1], SP←SP-1, go to BUBBLE.
  - IS_BRANCH=1, COND=01: PC←TARGET, go to BUBBLE.
  - IS_BRANCH=1, COND=11: if SP=DEPTH, go to HALT and hold PC. Otherwise stack[SP]←PC+1, SP←SP+1, PC←TARGET, go to BUBBLE.
  - IS_BRANCH=1, COND=00 or 10: PC←PC+1. Reserved code 10 is treated as not taken.
  - Neither flag set: PC←PC+1.
- BUBBLE lasts exactly one cycle and then returns to RUN unconditionally. In BUBBLE, PC, SP and stack hold, and STALL, INSTR_VALID, IS_BRANCH, IS_RET are ignored.
- HALT: everything holds. Only RST exits HALT.
- Arithmetic: PC+1 is modulo 2^AW, so PC=2^AW-1 increments to 0. A pushed return address wraps the same way.
- The stack is LIFO. An entry above SP is don't-care and is never read.

## Timing
- On a rising edge with RST=1: PC=RESET_PC, SP=0, state=RUN. This gives FETCH_EN=1, FLUSH=0, FAULT=0. Stack contents are not cleared.
- RST has priority over every other input, including in HALT and BUBBLE and mid-call.
- Redirect latency: TARGET or the popped address appears on PC on the edge that accepts the instruction. FLUSH=1 and FETCH_EN=0 for the following cycle. FETCH_EN returns to 1 one cycle later with PC unchanged.
- Sequential latency: PC advances once per unstalled RUN cycle.
- SP updates on the same edge as the PC redirect.
- FAULT rises on the edge that detects the overflow or underflow. PC holds the faulting value from that edge onward.
- Outputs are registered or state-decoded only. There is no combinational path from inputs to outputs.

## Test plan
- Reset then sequential run: RST for 2 cycles, then 5 idle cycles. Required: PC=0,1,2,3,4,5, FETCH_EN=1, SP=0, FLUSH=0.
- Taken jump and bubble: at PC=3, apply IS_BRANCH=1, COND=01, TARGET=8'h40. Required: next PC=40, one cycle FLUSH=1/FETCH_EN=0, PC stays 40, then PC=41. With COND=00 the next PC is 4 and no FLUSH.
- Call/return: call at PC=8'h10 to TARGET=8'h80. Required: SP=1, PC=80. Two idle cycles after BUBBLE give PC=82. Then IS_RET=1 gives PC=11, SP=0 and one FLUSH cycle.
- Overflow: 4 nested calls give SP=4. A fifth call gives FAULT=1, FETCH_EN=0, PC frozen at the caller. FAULT persists for 10 cycles and clears only after RST.
- Underflow, stall and wrap: IS_RET with SP=0 gives FAULT=1. After reset with RESET_PC=8'hFE, STALL=1 for 3 cycles holds PC=FE. Unstalled, PC goes FE, FF, 00. A call at PC=FF pushes return address 00.
- Priority and ignore: IS_RET and IS_BRANCH both set with COND=01 performs the return. Inputs asserted during BUBBLE or under STALL=1 change nothing.
